// File: rtl/fwd_pkg.sv
// Field layout, widths and result type shared by the forwarding lookup engine.
// No logic; latency and backpressure are defined by the modules that import it.
package fwd_pkg;

    localparam int KEY_W   = 8;
    localparam int TAG_W   = 24;
    localparam int PORT_W  = 4;
    localparam int ACT_W   = 11;
    localparam int DESC_W  = 32;
    localparam int ENTRY_W = 16;
    localparam int STAT_W  = 16;

    localparam int DESC_KEY_LSB = 0;
    localparam int DESC_TAG_LSB = 8;

    localparam int ENT_VLD_BIT  = 15;
    localparam int ENT_ACT_LSB  = 4;
    localparam int ENT_PORT_LSB = 0;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [PORT_W-1:0] port;
        logic [ACT_W-1:0]  action;
        logic              miss;
    } result_t;

    function automatic logic [KEY_W-1:0] desc_key(input logic [DESC_W-1:0] desc);
        return desc[DESC_KEY_LSB +: KEY_W];
    endfunction

    function automatic logic [TAG_W-1:0] desc_tag(input logic [DESC_W-1:0] desc);
        return desc[DESC_TAG_LSB +: TAG_W];
    endfunction

    // An entry without its valid bit is a miss: default port, no action bits.
    function automatic result_t build_result(
        input logic [TAG_W-1:0]   tag,
        input logic [ENTRY_W-1:0] entry,
        input logic [PORT_W-1:0]  dflt_port
    );
        result_t r;
        r.tag = tag;
        if (entry[ENT_VLD_BIT]) begin
            r.port   = entry[ENT_PORT_LSB +: PORT_W];
            r.action = entry[ENT_ACT_LSB +: ACT_W];
            r.miss   = 1'b0;
        end else begin
            r.port   = dflt_port;
            r.action = '0;
            r.miss   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_result_fifo.sv
// Synchronous result FIFO with occupancy count; a push is visible at the head one cycle later.
// Backpressure: a push into a full FIFO is dropped unless a pop happens in the same cycle.
module fwd_result_fifo
    import fwd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push_vld,
    input  result_t                push_dat,
    input  logic                   pop_rdy,
    output logic                   head_vld,
    output result_t                head_dat,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    result_t          mem_q [DEPTH];
    result_t          mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_rdy && (count_q != '0);
        do_push  = push_vld && ((count_q != FULL_CNT) || do_pop);

        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // Flush drops everything queued; storage contents are left as garbage.
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head_vld = (count_q != '0);
        head_dat = mem_q[rd_ptr_q];
        count    = count_q;
    end

endmodule

// File: rtl/fwd_lookup_engine.sv
// Forwarding lookup: descriptor -> S1 table read -> result FIFO; 2 cycles input to head when idle.
// Backpressure: in_ready drops once queued results plus the S1 lookup would fill the FIFO.
module fwd_lookup_engine
    import fwd_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [3:0]  DEFAULT_PORT = 4'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DESC_W-1:0]    in_desc,
    input  logic                 flush,
    output logic                 fwd_rden,
    output logic [KEY_W-1:0]     fwd_addr,
    input  logic [ENTRY_W-1:0]   fwd_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TAG_W-1:0]     out_tag,
    output logic [PORT_W-1:0]    out_port,
    output logic [ACT_W-1:0]     out_action,
    output logic                 out_miss,
    input  logic                 clr_cnt,
    output logic [STAT_W-1:0]    hit_cnt,
    output logic [STAT_W-1:0]    miss_cnt
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    logic              s1_vld_q, s1_vld_d;
    logic [DESC_W-1:0] s1_desc_q, s1_desc_d;
    logic [STAT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [STAT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [FCW-1:0]    fifo_count;
    logic [FCW:0]      occupancy;
    logic              fifo_head_vld;
    result_t           fifo_head;
    result_t           lookup_res;
    logic              in_fire;
    logic              push_vld;
    logic              pop_rdy;

    // Credit counts the S1 lookup as already occupying a FIFO slot.
    always_comb begin
        occupancy = {1'b0, fifo_count} + {{FCW{1'b0}}, s1_vld_q};
        in_ready  = !rst && (occupancy < (FCW+1)'(FIFO_DEPTH));
        in_fire   = in_valid && in_ready;

        s1_vld_d  = in_fire && !flush;
        s1_desc_d = in_fire ? in_desc : s1_desc_q;

        fwd_rden  = s1_vld_q && !rst;
        fwd_addr  = fwd_rden ? desc_key(s1_desc_q) : '0;

        lookup_res = build_result(desc_tag(s1_desc_q), fwd_rdata, DEFAULT_PORT);
        push_vld   = s1_vld_q && !flush;

        out_valid  = fifo_head_vld && !rst;
        pop_rdy    = out_valid && out_ready;
        out_tag    = out_valid ? fifo_head.tag    : '0;
        out_port   = out_valid ? fifo_head.port   : '0;
        out_action = out_valid ? fifo_head.action : '0;
        out_miss   = out_valid ? fifo_head.miss   : 1'b0;
    end

    // Statistics count pushes, so a flushed lookup never reaches them.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (clr_cnt) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (push_vld) begin
            if (!lookup_res.miss && (hit_cnt_q != '1)) begin
                hit_cnt_d = hit_cnt_q + STAT_W'(1);
            end
            if (lookup_res.miss && (miss_cnt_q != '1)) begin
                miss_cnt_d = miss_cnt_q + STAT_W'(1);
            end
        end
        hit_cnt  = rst ? '0 : hit_cnt_q;
        miss_cnt = rst ? '0 : miss_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_desc_q  <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_desc_q  <= s1_desc_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    fwd_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push_vld (push_vld),
        .push_dat (lookup_res),
        .pop_rdy  (pop_rdy),
        .head_vld (fifo_head_vld),
        .head_dat (fifo_head),
        .count    (fifo_count)
    );

endmodule
